// File: rtl/dense_argmax_select_if.sv
// dense_argmax_select_if: bundles the request and result signals of the top-2 search engine.
//   start       - request a search (sampled by the engine only while idle)
//   scores      - packed score vector, one signed DATA_W element per class
//   busy        - engine is scanning
//   done        - one-cycle strobe, results valid from this cycle on
//   class_idx   - index of the winning class
//   class_score - winning score (signed)
//   margin      - winner minus runner-up, DATA_W+1 bits unsigned
//   reject      - margin below the low-confidence threshold
// Modports: master drives the request side, slave is the search engine.
interface dense_argmax_select_if #(
  parameter int unsigned N_CLASSES = 10,
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned IDX_W     = 4
);

  logic                             start;
  logic [N_CLASSES-1:0][DATA_W-1:0] scores;
  logic                             busy;
  logic                             done;
  logic [IDX_W-1:0]                 class_idx;
  logic signed [DATA_W-1:0]         class_score;
  logic [DATA_W:0]                  margin;
  logic                             reject;

  modport master (
    output start,
    output scores,
    input  busy,
    input  done,
    input  class_idx,
    input  class_score,
    input  margin,
    input  reject
  );

  modport slave (
    input  start,
    input  scores,
    output busy,
    output done,
    output class_idx,
    output class_score,
    output margin,
    output reject
  );

endinterface

// File: rtl/dense_argmax_select.sv
// dense_argmax_select: sequential top-2 search over the final dense layer's score vector.
// On start the whole vector is snapshotted, then one element per cycle is compared against the
// running best and second-best. After the last element the winning index, its score, the
// winner-to-runner-up margin and a low-confidence reject flag are registered and done pulses.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - slave side of dense_argmax_select_if (start/scores in, busy/done/results out)
module dense_argmax_select #(
  parameter int unsigned N_CLASSES = 10,
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned MARGIN_TH = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  dense_argmax_select_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  localparam logic [IDX_W-1:0]         LastIdx  = IDX_W'(N_CLASSES - 1);
  localparam logic signed [DATA_W-1:0] MostNeg  = {1'b1, {(DATA_W - 1){1'b0}}};
  localparam logic [DATA_W:0]          MarginTh = (DATA_W + 1)'(MARGIN_TH);

  state_e                           state_q, state_d;
  logic [IDX_W-1:0]                 cnt_q, cnt_d;
  logic [N_CLASSES-1:0][DATA_W-1:0] snap_q, snap_d;
  logic signed [DATA_W-1:0]         best_q, best_d;
  logic signed [DATA_W-1:0]         second_q, second_d;
  logic [IDX_W-1:0]                 best_idx_q, best_idx_d;
  logic [IDX_W-1:0]                 class_idx_q, class_idx_d;
  logic signed [DATA_W-1:0]         class_score_q, class_score_d;
  logic [DATA_W:0]                  margin_q, margin_d;
  logic                             reject_q, reject_d;

  logic signed [DATA_W-1:0]         elem;
  logic [DATA_W:0]                  diff;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    snap_d        = snap_q;
    best_d        = best_q;
    second_d      = second_q;
    best_idx_d    = best_idx_q;
    class_idx_d   = class_idx_q;
    class_score_d = class_score_q;
    margin_d      = margin_q;
    reject_d      = reject_q;
    elem          = $signed(snap_q[cnt_q]);
    diff          = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          snap_d  = bus.scores;
          cnt_d   = '0;
          state_d = StScan;
        end
      end

      StScan: begin
        if (cnt_q == '0) begin
          best_d     = elem;
          best_idx_d = '0;
          second_d   = MostNeg;
        end else if (elem > best_q) begin
          // Strict compare: on a tie the earlier index stays best and the
          // equal value drops into second, giving a zero margin.
          second_d   = best_q;
          best_d     = elem;
          best_idx_d = cnt_q;
        end else if (elem > second_q) begin
          second_d = elem;
        end

        if (cnt_q == LastIdx) begin
          // Sign-extend by one bit so best - second never wraps; best >= second,
          // so the difference is always non-negative.
          diff          = {best_d[DATA_W-1], best_d} - {second_d[DATA_W-1], second_d};
          class_idx_d   = best_idx_d;
          class_score_d = best_d;
          margin_d      = diff;
          reject_d      = (diff < MarginTh);
          state_d       = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      snap_q        <= '0;
      best_q        <= '0;
      second_q      <= '0;
      best_idx_q    <= '0;
      class_idx_q   <= '0;
      class_score_q <= '0;
      margin_q      <= '0;
      reject_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      snap_q        <= snap_d;
      best_q        <= best_d;
      second_q      <= second_d;
      best_idx_q    <= best_idx_d;
      class_idx_q   <= class_idx_d;
      class_score_q <= class_score_d;
      margin_q      <= margin_d;
      reject_q      <= reject_d;
    end
  end

  // busy/done decode the registered state, so they carry no path from start or scores.
  assign bus.busy        = (state_q == StScan);
  assign bus.done        = (state_q == StDone);
  assign bus.class_idx   = class_idx_q;
  assign bus.class_score = class_score_q;
  assign bus.margin      = margin_q;
  assign bus.reject      = reject_q;

endmodule
